ysyx_24100012_fetch_pc: RTL and testbench



---
 rtl/ysyx_24100012_fetch_pc.sv | 141 ++++++++++++++
 tb/tb_ysyx_24100012_fetch_pc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100012_fetch_pc.sv
// ============================================================================
// Module   : ysyx_24100012_fetch_pc
// Purpose  : Architectural PC owner and instruction fetch unit. Issues fetches
//            over a valid/ready memory handshake, buffers one instruction for
//            decode, and cancels in-flight/buffered work on branch redirect.
// Options  : define FETCH_PERF_CNT_EN to add fetch/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_24100012_fetch_pc #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetch_cnt,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] target_aligned;
    logic                  unused_target_bits;

    // Instructions are word aligned; the low target bits are ignored.
    assign target_aligned     = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            inst_out <= '0;
            inst_pc  <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= target_aligned;
            case (state)
                S_REQ: begin
                    // A request accepted this cycle still owes us a response.
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state <= S_REQ;
                        drop  <= 1'b0;
                    end else begin
                        state <= S_WAIT;
                        drop  <= 1'b1;
                    end
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst_out <= imem_rsp_data;
                            inst_pc  <= pc;
                            state    <= S_HOLD;
                        end
                    end
                end
                default: begin
                    if (inst_ready) begin
                        pc    <= pc + ADDR_WIDTH'(4);
                        state <= S_REQ;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_evt;
    logic flush_evt;

    assign fetch_evt = (state == S_HOLD) && inst_ready && !redirect_valid;
    // A response is lost if it was already doomed or a redirect lands with it.
    assign flush_evt = ((state == S_WAIT) && imem_rsp_valid && (drop || redirect_valid))
                    || ((state == S_HOLD) && redirect_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_evt) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (flush_evt) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ysyx_24100012_fetch_pc.sv
// Randomized bench for ysyx_24100012_fetch_pc: a memory model, a delivery
// scoreboard driven by a PC-level reference model, and a decoupled monitor.
`default_nettype none

module tb_ysyx_24100012_fetch_pc;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    ysyx_24100012_fetch_pc dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } pend_t;

    exp_t        exp_q[$];    // next instruction decode must see
    pend_t       pend_q[$];   // requests accepted by memory, not yet answered
    logic [31:0] model_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_flush;
    bit          mon_en = 1'b0;
    bit          last_redirect = 1'b0;
    int          idle_cycles = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5C3_0013;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        model_pc = RESET_PC;
        exp_q.delete();
        exp_q.push_back('{RESET_PC, mem_word(RESET_PC)});
        pend_q.delete();
        m_fetch = '0;
        m_flush = '0;
        last_redirect = 1'b0;
        idle_cycles = 0;
    endtask

    // Monitor: compares DUT outputs against the reference model each cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            check32("req_addr", imem_req_addr, model_pc);
            if (last_redirect) begin
                check32("inst_valid_after_redirect", {31'b0, inst_valid}, 32'd0);
            end
            if (inst_valid) begin
                idle_cycles = 0;
                check32("req_valid_in_hold", {31'b0, imem_req_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    check32("scoreboard_empty", 32'd0, 32'd1);
                end else begin
                    check32("inst_pc", inst_pc, exp_q[0].pc);
                    check32("inst_out", inst_out, exp_q[0].data);
                end
            end else begin
                idle_cycles++;
                if (idle_cycles > 300) begin
                    check32("delivery_timeout", 32'(idle_cycles), 32'd300);
                    idle_cycles = 0;
                end
            end
`ifdef FETCH_PERF_CNT_EN
            check32("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
            check32("perf_flush_cnt", perf_flush_cnt, m_flush);
`endif
        end
    end

    // One cycle of stimulus; the reference model advances by the same cycle.
    task automatic step(input int p_redir, input int p_rdy, input int p_rsp, input int p_irdy,
                        input bit force_redir, input logic [31:0] force_tgt);
        logic        s_req;
        logic        s_iv;
        logic [31:0] s_addr;
        bit          redir;
        bit          rdy;
        bit          rsp;
        bit          irdy;
        logic [31:0] tgt;
        @(negedge clk);
        #1;
        s_req  = imem_req_valid;
        s_iv   = inst_valid;
        s_addr = imem_req_addr;
        redir  = force_redir || ($urandom_range(99) < p_redir);
        case ($urandom_range(4))
            0: tgt = 32'h8000_0100;
            1: tgt = 32'h8000_0203;
            2: tgt = 32'hFFFF_FFFC;
            3: tgt = 32'hFFFF_FFFF;
            default: tgt = $urandom;
        endcase
        if (force_redir) tgt = force_tgt;
        rdy  = ($urandom_range(99) < p_rdy);
        irdy = ($urandom_range(99) < p_irdy);
        rsp  = (pend_q.size() > 0) && ($urandom_range(99) < p_rsp);

        redirect_valid  = redir;
        redirect_target = tgt;
        imem_req_ready  = rdy;
        inst_ready      = irdy;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = rsp ? mem_word(pend_q[0].addr) : $urandom;

        if (rsp) begin
            if (pend_q[0].stale || redir) m_flush++;
            void'(pend_q.pop_front());
        end
        if (redir) begin
            foreach (pend_q[i]) pend_q[i].stale = 1'b1;
        end
        if (s_req && rdy) pend_q.push_back('{s_addr, redir});

        if (redir) begin
            if (s_iv) m_flush++;
            model_pc = tgt & ~32'd3;
            exp_q.delete();
            exp_q.push_back('{model_pc, mem_word(model_pc)});
        end else if (s_iv && irdy) begin
            m_fetch++;
            void'(exp_q.pop_front());
            model_pc = model_pc + 32'd4;
            exp_q.push_back('{model_pc, mem_word(model_pc)});
        end
        last_redirect = redir;
    endtask

    task automatic quiet_inputs();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        inst_ready     = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        quiet_inputs();
        rst_n = 1'b0;
        #1;
        check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("rst_req_addr", imem_req_addr, RESET_PC);
        check32("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        check32("rst_inst_out", inst_out, 32'd0);
        check32("rst_inst_pc", inst_pc, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
        check32("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check32("rst_perf_flush", perf_flush_cnt, 32'd0);
`endif
        model_reset();
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset_pulse();

        repeat (30) step(0, 100, 100, 100, 1'b0, '0);
        repeat (12) step(0, 100, 100, 0, 1'b0, '0);
        repeat (4) step(0, 100, 100, 100, 1'b0, '0);

        step(0, 100, 100, 100, 1'b1, 32'hFFFF_FFFC);
        repeat (20) step(0, 100, 100, 100, 1'b0, '0);
        step(0, 100, 100, 100, 1'b1, 32'h8000_0203);
        repeat (10) step(0, 100, 100, 100, 1'b0, '0);

        repeat (1500) step(6, 70, 60, 60, 1'b0, '0);
        repeat (1000) step(15, 50, 50, 80, 1'b0, '0);

        reset_pulse();
        repeat (800) step(8, 60, 70, 50, 1'b0, '0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
